jtopl_lfo_dual: RTL and testbench
=================================

# jtopl_lfo_dual

Dual low-frequency oscillator for the OPL operator pipeline. It produces a triangle tremolo (AM) level and an 8-step vibrato (PM) code from the per-sample tick `cenop && zero`. Each waveform has its own parametrised prescaler and a depth select. It generalises the single saw-counter LFO: it adds the second channel, the up/down triangle, depth modes and an optional synchronous test reset. Outputs feed the envelope attenuation adder (AM) and the phase-increment modulator (PM).

## Interface
- `AM_DIV`, 64: sample ticks per AM level step (≥2)
- `AM_MAX`, 26: triangle peak level; AM level spans 0..AM_MAX
- `PM_DIV`, 1024: sample ticks per PM step (≥2)
- `W`, 5: AM level/output width; AM_MAX < 2^W required
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cenop`  in  1  operator clock enable
- `zero`  in  1  first-slot marker; `cenop && zero` is the sample tick
- `dam`  in  1  AM depth: 1 = deep (full level), 0 = shallow (level >> 2)
- `dvb`  in  1  PM depth: 1 = deep, 0 = shallow
- `lfo_rst`  in  1  synchronous LFO clear (test register bit); only used with the macro
- `am_mod`  out  W  tremolo attenuation level
- `vb_sign`  out  1  vibrato sign (1 = negative)
- `vb_mag`  out  2  vibrato magnitude 0..2 (deep) or 0..1 (shallow)

## Operation
- Tick = `cenop && zero`. All state advances only on a tick.
- AM prescaler `am_cnt` has width clog2(AM_DIV). It counts 0..AM_DIV-1 and wraps to 0. The wrap tick is the AM step.
- AM triangle: `am_lvl` (W bits) and direction flag `am_dn`.
  - On an AM step with am_dn=0: if am_lvl==AM_MAX-1, set am_lvl=AM_MAX and am_dn=1; otherwise increment am_lvl.
  - On an AM step with am_dn=1: if am_lvl==1, set am_lvl=0 and am_dn=0; otherwise decrement am_lvl.
  - Peak and trough are each held for exactly one step. Full period = 2·AM_MAX·AM_DIV ticks (3328 at defaults).
- PM prescaler `pm_cnt` counts 0..PM_DIV-1 and wraps to 0. On wrap, the 3-bit `pm_step` increments and wraps 7→0.
- PM decode:
  - vb_sign = pm_step[2].
  - Deep magnitude by pm_step[1:0]: 0,1,2,1.
  - Shallow magnitude = deep >> 1, giving 0,0,1,0.
- am_mod = dam ? am_lvl : am_lvl >> 2.
- Depth inputs affect the output decode only, never the oscillator state.

## Timing
- Reset (rst_n low, asynchronous): am_cnt=0, pm_cnt=0, am_lvl=0, am_dn=0, pm_step=0, am_mod=0, vb_sign=0, vb_mag=0.
- Release of rst_n is synchronised by the existing reset scheme. The first tick after release increments the counters.
- All outputs are registered and updated every clk from the current state and the depth inputs.
  - State changes appear on the outputs one clk after the tick edge.
  - A dam/dvb change appears one clk later.
- Non-tick cycles: state holds. A `cenop` without `zero` (or `zero` without `cenop`) does nothing.
- Both prescalers may wrap on the same tick. The AM and PM steps are then independent and both apply.
- With the macro enabled, if lfo_rst and a tick are both high, lfo_rst wins. State goes to reset values and that tick is discarded.

## Configuration
- `JTOPL_LFO_TESTRST_EN`
  - Defined: lfo_rst high on any clk clears am_cnt, pm_cnt, am_lvl, am_dn and pm_step to reset values (synchronous, no tick needed). Outputs follow one clk later.
  - Not defined: lfo_rst is ignored and no logic is built for it.

## Test plan
- Reset, then 200 idle clks with zero=0 and cenop toggling → am_mod=0, vb_sign=0, vb_mag=0 throughout.
- AM_DIV=4, AM_MAX=3, dam=1, continuous ticks → am_mod sequence 0,1,2,3,2,1,0,1…, each value lasting 4 ticks; period 24 ticks.
- Default params, dam=0, run to the AM peak (1664 ticks) → am_mod=6 (26>>2); switch dam=1 → am_mod=26 one clk later.
- PM_DIV=2, dvb=1 → (sign,mag) per step: (0,0),(0,1),(0,2),(0,1),(1,0),(1,1),(1,2),(1,1), then repeat. Repeat with dvb=0 → mags 0,0,1,0.
- Macro defined: run 37 ticks, assert lfo_rst on the same clk as a tick → all state and outputs back to 0; the next tick gives am_cnt=1. Macro undefined, same stimulus → no effect.
- Assert rst_n low asynchronously mid-triangle (am_lvl=13, am_dn=1) → outputs 0 immediately; after release the triangle restarts rising from 0.

Source files
------------

// File: rtl/jtopl_lfo_dual.sv
// jtopl_lfo_dual
//
// Dual low-frequency oscillator for the OPL operator pipeline.
//   - AM channel: triangle tremolo level that steps once every AM_DIV sample
//     ticks, rising 0..AM_MAX and falling back to 0. Peak and trough are each
//     held for a single step.
//   - PM channel: 3-bit vibrato step that advances once every PM_DIV sample
//     ticks and is decoded into a sign and a small magnitude.
// A sample tick is cenop && zero. All oscillator state only moves on a tick.
// The depth inputs (dam, dvb) only shape the registered output decode.
//
// Optional feature macro: JTOPL_LFO_TESTRST_EN
//   When defined, lfo_rst synchronously clears all oscillator state and
//   overrides a coincident tick. When undefined, lfo_rst is ignored.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   cenop    in   operator clock enable
//   zero     in   first-slot marker (tick = cenop && zero)
//   dam      in   AM depth: 1 = full level, 0 = level >> 2
//   dvb      in   PM depth: 1 = deep (mag 0..2), 0 = shallow (mag 0..1)
//   lfo_rst  in   synchronous LFO clear (only with JTOPL_LFO_TESTRST_EN)
//   am_mod   out  tremolo attenuation level (W bits)
//   vb_sign  out  vibrato sign (1 = negative)
//   vb_mag   out  vibrato magnitude
module jtopl_lfo_dual #(
  parameter int AM_DIV = 64,
  parameter int AM_MAX = 26,
  parameter int PM_DIV = 1024,
  parameter int W      = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cenop,
  input  logic         zero,
  input  logic         dam,
  input  logic         dvb,
  input  logic         lfo_rst,
  output logic [W-1:0] am_mod,
  output logic         vb_sign,
  output logic [1:0]   vb_mag
);

  localparam int AMCW = $clog2(AM_DIV);
  localparam int PMCW = $clog2(PM_DIV);

  localparam logic [AMCW-1:0] AM_CNT_LAST = AMCW'(AM_DIV - 1);
  localparam logic [PMCW-1:0] PM_CNT_LAST = PMCW'(PM_DIV - 1);
  localparam logic [W-1:0]    AM_PEAK     = W'(AM_MAX);
  localparam logic [W-1:0]    AM_PRE_PEAK = W'(AM_MAX - 1);
  localparam logic [W-1:0]    AM_ONE      = W'(1);

  logic [AMCW-1:0] am_cnt_q,  am_cnt_d;
  logic [PMCW-1:0] pm_cnt_q,  pm_cnt_d;
  logic [W-1:0]    am_lvl_q,  am_lvl_d;
  logic            am_dn_q,   am_dn_d;
  logic [2:0]      pm_step_q, pm_step_d;

  logic [W-1:0]    am_mod_q,  am_mod_d;
  logic            vb_sign_q, vb_sign_d;
  logic [1:0]      vb_mag_q,  vb_mag_d;

  logic            tick;
  logic            am_wrap;
  logic            pm_wrap;
  logic [1:0]      deep_mag;

  assign tick    = cenop & zero;
  assign am_wrap = (am_cnt_q == AM_CNT_LAST);
  assign pm_wrap = (pm_cnt_q == PM_CNT_LAST);

`ifndef JTOPL_LFO_TESTRST_EN
  // lfo_rst is only meaningful with the test-reset feature; the name keeps
  // the unused-signal lint check quiet without building any logic.
  logic unused_lfo_rst;
  assign unused_lfo_rst = lfo_rst;
`endif

  // Oscillator next-state. Both prescalers are independent, so an AM step
  // and a PM step landing on the same tick are both applied.
  always_comb begin
    am_cnt_d  = am_cnt_q;
    pm_cnt_d  = pm_cnt_q;
    am_lvl_d  = am_lvl_q;
    am_dn_d   = am_dn_q;
    pm_step_d = pm_step_q;

    if (tick) begin
      am_cnt_d = am_wrap ? '0 : am_cnt_q + AMCW'(1);
      pm_cnt_d = pm_wrap ? '0 : pm_cnt_q + PMCW'(1);

      // Direction flips on the step that lands on the peak or trough, so
      // each extreme is held for exactly one step.
      if (am_wrap) begin
        if (!am_dn_q) begin
          if (am_lvl_q == AM_PRE_PEAK) begin
            am_lvl_d = AM_PEAK;
            am_dn_d  = 1'b1;
          end else begin
            am_lvl_d = am_lvl_q + AM_ONE;
          end
        end else begin
          if (am_lvl_q == AM_ONE) begin
            am_lvl_d = '0;
            am_dn_d  = 1'b0;
          end else begin
            am_lvl_d = am_lvl_q - AM_ONE;
          end
        end
      end

      if (pm_wrap) begin
        pm_step_d = pm_step_q + 3'd1;
      end
    end

`ifdef JTOPL_LFO_TESTRST_EN
    // Test clear beats a coincident tick; that tick is simply lost.
    if (lfo_rst) begin
      am_cnt_d  = '0;
      pm_cnt_d  = '0;
      am_lvl_d  = '0;
      am_dn_d   = 1'b0;
      pm_step_d = '0;
    end
`endif
  end

  // Output decode from the current state. Vibrato magnitude follows the
  // pattern 0,1,2,1 over the low two step bits; shallow depth halves it.
  always_comb begin
    case (pm_step_q[1:0])
      2'd0:    deep_mag = 2'd0;
      2'd1:    deep_mag = 2'd1;
      2'd2:    deep_mag = 2'd2;
      default: deep_mag = 2'd1;
    endcase

    am_mod_d  = dam ? am_lvl_q : (am_lvl_q >> 2);
    vb_sign_d = pm_step_q[2];
    vb_mag_d  = dvb ? deep_mag : (deep_mag >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_cnt_q  <= '0;
      pm_cnt_q  <= '0;
      am_lvl_q  <= '0;
      am_dn_q   <= 1'b0;
      pm_step_q <= '0;
      am_mod_q  <= '0;
      vb_sign_q <= 1'b0;
      vb_mag_q  <= 2'd0;
    end else begin
      am_cnt_q  <= am_cnt_d;
      pm_cnt_q  <= pm_cnt_d;
      am_lvl_q  <= am_lvl_d;
      am_dn_q   <= am_dn_d;
      pm_step_q <= pm_step_d;
      am_mod_q  <= am_mod_d;
      vb_sign_q <= vb_sign_d;
      vb_mag_q  <= vb_mag_d;
    end
  end

  assign am_mod  = am_mod_q;
  assign vb_sign = vb_sign_q;
  assign vb_mag  = vb_mag_q;

endmodule

// File: tb/tb_jtopl_lfo_dual.sv
// Testbench for jtopl_lfo_dual. Two instances share all inputs: one with the
// default parameters and a small one (AM_DIV=4, AM_MAX=3, PM_DIV=2) whose
// waveforms are short enough to walk through cycle by cycle.
module tb_jtopl_lfo_dual;

  logic       clk;
  logic       rst_n;
  logic       cenop;
  logic       zero;
  logic       dam;
  logic       dvb;
  logic       lfo_rst;

  logic [4:0] am_mod_def;
  logic       vb_sign_def;
  logic [1:0] vb_mag_def;
  logic [4:0] am_mod_sm;
  logic       vb_sign_sm;
  logic [1:0] vb_mag_sm;

  int n_checks;
  int n_fail;

`ifdef JTOPL_LFO_TESTRST_EN
  localparam bit HAS_TESTRST = 1'b1;
`else
  localparam bit HAS_TESTRST = 1'b0;
`endif

  jtopl_lfo_dual dut_def (
    .clk     (clk),
    .rst_n   (rst_n),
    .cenop   (cenop),
    .zero    (zero),
    .dam     (dam),
    .dvb     (dvb),
    .lfo_rst (lfo_rst),
    .am_mod  (am_mod_def),
    .vb_sign (vb_sign_def),
    .vb_mag  (vb_mag_def)
  );

  jtopl_lfo_dual #(
    .AM_DIV (4),
    .AM_MAX (3),
    .PM_DIV (2),
    .W      (5)
  ) dut_sm (
    .clk     (clk),
    .rst_n   (rst_n),
    .cenop   (cenop),
    .zero    (zero),
    .dam     (dam),
    .dvb     (dvb),
    .lfo_rst (lfo_rst),
    .am_mod  (am_mod_sm),
    .vb_sign (vb_sign_sm),
    .vb_mag  (vb_mag_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed-form expectations for the small instance after n ticks.
  function automatic logic [4:0] exp_am_sm(input int n);
    int p;
    p = (n / 4) % 6;
    return (p <= 3) ? 5'(p) : 5'(6 - p);
  endfunction

  function automatic logic exp_sign_sm(input int n);
    return (((n / 2) % 8) >= 4);
  endfunction

  function automatic logic [1:0] exp_mag_sm(input int n, input logic deep);
    int s;
    logic [1:0] m;
    s = (n / 2) % 4;
    m = (s == 2) ? 2'd2 : ((s == 0) ? 2'd0 : 2'd1);
    return deep ? m : (m >> 1);
  endfunction

  // Holds a tick for n consecutive clock edges, ending on a negedge with
  // the tick inputs low again.
  task automatic do_ticks(input int n);
    @(negedge clk);
    cenop = 1'b1;
    zero  = 1'b1;
    repeat (n) @(negedge clk);
    cenop = 1'b0;
    zero  = 1'b0;
  endtask

  task automatic apply_reset;
    cenop   = 1'b0;
    zero    = 1'b0;
    lfo_rst = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    cenop   = 1'b0;
    zero    = 1'b0;
    lfo_rst = 1'b0;
    dam     = 1'b1;
    dvb     = 1'b1;
    rst_n   = 1'b0;
    #12;
    n_checks++;
    if ({am_mod_def, vb_sign_def, vb_mag_def, am_mod_sm, vb_sign_sm, vb_mag_sm} !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got def=%0d/%0b/%0d sm=%0d/%0b/%0d, want all 0",
               am_mod_def, vb_sign_def, vb_mag_def, am_mod_sm, vb_sign_sm, vb_mag_sm);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // cenop toggling without zero must never tick
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cenop = ~cenop;
      n_checks++;
      if ({am_mod_def, vb_sign_def, vb_mag_def, am_mod_sm, vb_sign_sm, vb_mag_sm} !== 16'h0) begin
        n_fail++;
        $display("[TB] FAIL idle_no_zero cycle %0d: got def=%0d/%0b/%0d sm=%0d/%0b/%0d, want all 0",
                 i, am_mod_def, vb_sign_def, vb_mag_def, am_mod_sm, vb_sign_sm, vb_mag_sm);
      end
    end
    cenop = 1'b0;
  endtask

  // Continuous ticks on the small instance: each sample at negedge k reflects
  // the state after k-1 ticks. dvb switches to shallow halfway through.
  task automatic test_triangle_and_vibrato;
    logic dvb_now;
    apply_reset;
    dam     = 1'b1;
    dvb     = 1'b1;
    dvb_now = 1'b1;
    @(negedge clk);
    cenop = 1'b1;
    zero  = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      n_checks++;
      if (am_mod_sm !== exp_am_sm(k - 1)) begin
        n_fail++;
        $display("[TB] FAIL am_triangle n=%0d: got %0d, want %0d", k - 1, am_mod_sm, exp_am_sm(k - 1));
      end
      n_checks++;
      if ({vb_sign_sm, vb_mag_sm} !== {exp_sign_sm(k - 1), exp_mag_sm(k - 1, dvb_now)}) begin
        n_fail++;
        $display("[TB] FAIL vibrato n=%0d dvb=%0b: got sign=%0b mag=%0d, want sign=%0b mag=%0d",
                 k - 1, dvb_now, vb_sign_sm, vb_mag_sm, exp_sign_sm(k - 1), exp_mag_sm(k - 1, dvb_now));
      end
      if (k == 24) begin
        dvb     = 1'b0;
        dvb_now = 1'b0;
      end
    end
    cenop = 1'b0;
    zero  = 1'b0;
  endtask

  // zero without cenop must not tick; state holds.
  task automatic test_hold;
    logic [4:0] am_before;
    logic [2:0] vb_before;
    @(negedge clk);
    am_before = am_mod_sm;
    vb_before = {vb_sign_sm, vb_mag_sm};
    zero = 1'b1;
    repeat (20) @(negedge clk);
    zero = 1'b0;
    n_checks++;
    if ({am_mod_sm, vb_sign_sm, vb_mag_sm} !== {am_before, vb_before}) begin
      n_fail++;
      $display("[TB] FAIL hold_zero_only: got %0d/%0b/%0d, want %0d/%0b/%0d",
               am_mod_sm, vb_sign_sm, vb_mag_sm, am_before, vb_before[2], vb_before[1:0]);
    end
  endtask

  task automatic test_am_depth;
    apply_reset;
    dam = 1'b0;
    dvb = 1'b1;
    do_ticks(1664);
    @(negedge clk);
    n_checks++;
    if (am_mod_def !== 5'd6) begin
      n_fail++;
      $display("[TB] FAIL am_peak_shallow: got %0d, want 6", am_mod_def);
    end
    n_checks++;
    if ({vb_sign_def, vb_mag_def} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL pm_default_step1: got sign=%0b mag=%0d, want sign=0 mag=1", vb_sign_def, vb_mag_def);
    end
    dam = 1'b1;
    @(negedge clk);
    n_checks++;
    if (am_mod_def !== 5'd26) begin
      n_fail++;
      $display("[TB] FAIL am_peak_deep: got %0d, want 26", am_mod_def);
    end
  endtask

  task automatic test_lfo_rst;
    int n0;
    n0 = HAS_TESTRST ? 0 : 38;
    apply_reset;
    dam = 1'b1;
    dvb = 1'b1;
    do_ticks(37);
    cenop   = 1'b1;
    zero    = 1'b1;
    lfo_rst = 1'b1;
    @(negedge clk);
    cenop   = 1'b0;
    zero    = 1'b0;
    lfo_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({am_mod_sm, vb_sign_sm, vb_mag_sm} !== {exp_am_sm(n0), exp_sign_sm(n0), exp_mag_sm(n0, 1'b1)}) begin
      n_fail++;
      $display("[TB] FAIL lfo_rst_clear: got %0d/%0b/%0d, want %0d/%0b/%0d", am_mod_sm, vb_sign_sm, vb_mag_sm,
               exp_am_sm(n0), exp_sign_sm(n0), exp_mag_sm(n0, 1'b1));
    end
    if (HAS_TESTRST) begin
      n_checks++;
      if (am_mod_def !== 5'd0) begin
        n_fail++;
        $display("[TB] FAIL lfo_rst_clear_def: got %0d, want 0", am_mod_def);
      end
    end
    do_ticks(3);
    @(negedge clk);
    n_checks++;
    if ({am_mod_sm, vb_mag_sm} !== {exp_am_sm(n0 + 3), exp_mag_sm(n0 + 3, 1'b1)}) begin
      n_fail++;
      $display("[TB] FAIL lfo_rst_after3: got am=%0d mag=%0d, want am=%0d mag=%0d",
               am_mod_sm, vb_mag_sm, exp_am_sm(n0 + 3), exp_mag_sm(n0 + 3, 1'b1));
    end
    do_ticks(1);
    @(negedge clk);
    n_checks++;
    if ({am_mod_sm, vb_mag_sm} !== {exp_am_sm(n0 + 4), exp_mag_sm(n0 + 4, 1'b1)}) begin
      n_fail++;
      $display("[TB] FAIL lfo_rst_after4: got am=%0d mag=%0d, want am=%0d mag=%0d",
               am_mod_sm, vb_mag_sm, exp_am_sm(n0 + 4), exp_mag_sm(n0 + 4, 1'b1));
    end
  endtask

  // Falling through level 13 (step 39), reset asynchronously mid-cycle.
  task automatic test_async_reset;
    apply_reset;
    dam = 1'b1;
    dvb = 1'b1;
    do_ticks(2496);
    @(negedge clk);
    n_checks++;
    if (am_mod_def !== 5'd13) begin
      n_fail++;
      $display("[TB] FAIL am_falling_13: got %0d, want 13", am_mod_def);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({am_mod_def, vb_sign_def, vb_mag_def} !== 8'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_immediate: got %0d/%0b/%0d, want 0/0/0", am_mod_def, vb_sign_def, vb_mag_def);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_ticks(64);
    @(negedge clk);
    n_checks++;
    if (am_mod_def !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL restart_rise_1: got %0d, want 1", am_mod_def);
    end
    do_ticks(64);
    @(negedge clk);
    n_checks++;
    if (am_mod_def !== 5'd2) begin
      n_fail++;
      $display("[TB] FAIL restart_rise_2: got %0d, want 2", am_mod_def);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    cenop    = 1'b0;
    zero     = 1'b0;
    dam      = 1'b1;
    dvb      = 1'b1;
    lfo_rst  = 1'b0;
    test_reset;
    test_triangle_and_vibrato;
    test_hold;
    test_am_depth;
    test_lfo_rst;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
